adc_hyst_comp: RTL



---
 rtl/adc_hyst_comp.sv | 117 +++++++++++
 1 files changed

// File: rtl/adc_hyst_comp.sv
// Decimating, averaging ADC comparator with a symmetric hysteresis band and debounced decision strobes.
// Optional decision toggle counter is built when ADC_COMP_STATS_EN is defined.
module adc_hyst_comp #(
    parameter int ADC_W      = 12,
    parameter int AVG_LOG2   = 3,
    parameter int SAMPLE_DIV = 50,
    parameter int THRESH     = 2048,
    parameter int HYST       = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             swipt_alive,
    input  logic [ADC_W-1:0] adc,
    output logic             adc_comp,
    output logic             comp_valid,
    output logic             comp_toggle,
    output logic [ADC_W-1:0] avg_out,
    output logic [15:0]      toggle_count
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ADC_W-1:0] LO_TH      = ADC_W'(THRESH - HYST);
    localparam logic [ADC_W-1:0] HI_TH      = ADC_W'(THRESH + HYST);

    generate
        if (ADC_W < 1 || AVG_LOG2 < 0 || SAMPLE_DIV < 2 || HYST < 0 ||
            HYST > THRESH || (THRESH + HYST) > ((1 << ADC_W) - 1)) begin : g_bad_params
            $error("adc_hyst_comp: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] sample_cnt_reg;

    logic             clear;
    logic             strobe;
    logic [ACC_W-1:0] sum;
    logic             comp_next;

    assign clear  = !nrst || !swipt_alive;
    assign strobe = (div_cnt_reg == '0);
    // Width of acc is chosen so a full window of full-scale samples cannot wrap.
    assign sum    = acc_reg + ACC_W'(adc);

    always_comb begin
        comp_next = adc_comp;
        if (avg_out < LO_TH)
            comp_next = 1'b1;
        else if (avg_out >= HI_TH)
            comp_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg      <= IDLE;
            div_cnt_reg    <= DIV_RELOAD;
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
            avg_out        <= '0;
            adc_comp       <= 1'b0;
            comp_valid     <= 1'b0;
            comp_toggle    <= 1'b0;
        end else begin
            comp_valid  <= 1'b0;
            comp_toggle <= 1'b0;
            if (state_reg == IDLE) begin
                state_reg <= ACCUM;
            end else begin
                div_cnt_reg <= strobe ? DIV_RELOAD : div_cnt_reg - DIV_W'(1);

                if (state_reg == DECIDE) begin
                    adc_comp    <= comp_next;
                    comp_valid  <= 1'b1;
                    comp_toggle <= (comp_next != adc_comp);
                    state_reg   <= ACCUM;
                end

                // Divider keeps running through DECIDE, so a strobe here is never dropped.
                if (strobe) begin
                    if (sample_cnt_reg == LAST_CNT) begin
                        avg_out        <= sum[ACC_W-1:AVG_LOG2];
                        acc_reg        <= '0;
                        sample_cnt_reg <= '0;
                        state_reg      <= DECIDE;
                    end else begin
                        acc_reg        <= sum;
                        sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef ADC_COMP_STATS_EN
    logic toggled;
    assign toggled = (state_reg == DECIDE) && (comp_next != adc_comp);

    always_ff @(posedge clk) begin
        if (clear)
            toggle_count <= '0;
        else if (toggled && toggle_count != 16'hFFFF)
            toggle_count <= toggle_count + 16'd1;
    end
`else
    assign toggle_count = '0;
`endif

endmodule
